// File: rtl/ethmac_tx_fcs_ctrl.sv
`timescale 1ns/1ps
// Ethernet MAC TX sequencer: passes payload to MAC/CRC, optionally pads short frames, appends FCS, enforces IFG.
// Latency: one register stage (word accepted at edge N is on o_mac_* from N to N+1); FCS follows CRC_LAT idle cycles.
// Backpressure: o_tx_ready only in IDLE/DATA; a missing word in DATA aborts the frame with o_underrun, never stalls.
//
// Optional feature macro: ETHMAC_TX_PAD_EN -- when defined, frames shorter than MIN_WORDS are padded with 0x0000.
// Ports:
//   i_clk, i_rst_n                          clock, asynchronous active-low reset
//   i_tx_data/i_tx_valid/i_tx_last/o_tx_ready  payload stream from the frame builder
//   o_mac_data/o_mac_valid/o_mac_last         outgoing word stream (o_mac_last marks the final FCS word)
//   o_crc_reset/o_crc_en/o_crc_data, i_crc    CRC-32 engine control and its final FCS result
//   o_underrun                                one-cycle pulse when a frame is aborted on an input gap
//   o_busy                                    high whenever the sequencer is not idle
module ethmac_tx_fcs_ctrl #(
    parameter int CRC_LAT   = 2,
    parameter int IFG_WORDS = 6,
    parameter int MIN_WORDS = 30
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_tx_data,
    input  logic        i_tx_valid,
    input  logic        i_tx_last,
    output logic        o_tx_ready,
    output logic [15:0] o_mac_data,
    output logic        o_mac_valid,
    output logic        o_mac_last,
    output logic        o_crc_reset,
    output logic        o_crc_en,
    output logic [15:0] o_crc_data,
    input  logic [31:0] i_crc,
    output logic        o_underrun,
    output logic        o_busy
);

    generate
        if (CRC_LAT < 1 || CRC_LAT > 7 || IFG_WORDS < 1 || IFG_WORDS > 63 ||
            MIN_WORDS < 1 || MIN_WORDS > 2047) begin : g_bad_param
            $error("ethmac_tx_fcs_ctrl: parameter out of range");
        end
    endgenerate

    localparam logic [2:0]  CRC_LAT_W   = 3'(CRC_LAT);
    localparam logic [5:0]  IFG_LAST    = 6'(IFG_WORDS - 1);
`ifdef ETHMAC_TX_PAD_EN
    localparam logic [10:0] MIN_WORDS_W = 11'(MIN_WORDS);
`endif

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DATA     = 3'd1,
`ifdef ETHMAC_TX_PAD_EN
        ST_PAD      = 3'd2,
`endif
        ST_WAIT_CRC = 3'd3,
        ST_FCS_HI   = 3'd4,
        ST_FCS_LO   = 3'd5,
        ST_IFG      = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [2:0]  wait_q, wait_d;
    logic [5:0]  ifg_q, ifg_d;
    logic [15:0] data_q, data_d;
    logic        vld_q, vld_d;
    logic        last_q, last_d;
    logic        crc_en_q, crc_en_d;
    logic        crc_rst_q, crc_rst_d;
    logic        rdy_q, rdy_d;
    logic        udr_q, udr_d;

    logic        take;
    logic        load_word;
    logic [10:0] cnt_inc;
    logic [10:0] cnt_acc;

    // Ready is a register, so it is low during reset and rises one edge after release.
    assign take    = rdy_q & i_tx_valid;
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 11'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        ifg_d     = ifg_q;
        data_d    = 16'h0000;
        vld_d     = 1'b0;
        last_d    = 1'b0;
        crc_en_d  = 1'b0;
        crc_rst_d = 1'b0;
        rdy_d     = 1'b0;
        udr_d     = 1'b0;
        load_word = 1'b0;
        cnt_acc   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                crc_rst_d = 1'b1;
                rdy_d     = 1'b1;
                if (take) begin
                    state_d   = ST_DATA;
                    cnt_acc   = 11'd1;
                    load_word = 1'b1;
                end
            end
            ST_DATA: begin
                rdy_d = 1'b1;
                if (take) begin
                    cnt_acc   = cnt_inc;
                    load_word = 1'b1;
                end else begin
                    // Input gap mid-frame: abort without FCS and go straight to the gap.
                    udr_d     = 1'b1;
                    rdy_d     = 1'b0;
                    crc_rst_d = 1'b1;
                    ifg_d     = '0;
                    state_d   = ST_IFG;
                end
            end
`ifdef ETHMAC_TX_PAD_EN
            ST_PAD: begin
                vld_d    = 1'b1;
                crc_en_d = 1'b1;
                cnt_d    = cnt_inc;
                if (cnt_inc >= MIN_WORDS_W) begin
                    wait_d  = '0;
                    state_d = ST_WAIT_CRC;
                end
            end
`endif
            ST_WAIT_CRC: begin
                // Entered on the edge that loads the final CRC word, so CRC_LAT further
                // increments leave exactly CRC_LAT idle cycles before FCS_HI.
                if (wait_q == CRC_LAT_W) begin
                    data_d  = i_crc[31:16];
                    vld_d   = 1'b1;
                    state_d = ST_FCS_HI;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            ST_FCS_HI: begin
                data_d  = i_crc[15:0];
                vld_d   = 1'b1;
                last_d  = 1'b1;
                state_d = ST_FCS_LO;
            end
            ST_FCS_LO: begin
                crc_rst_d = 1'b1;
                ifg_d     = '0;
                state_d   = ST_IFG;
            end
            ST_IFG: begin
                crc_rst_d = 1'b1;
                if (ifg_q == IFG_LAST) begin
                    rdy_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    ifg_d = ifg_q + 6'd1;
                end
            end
            default: begin
                crc_rst_d = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase

        if (load_word) begin
            data_d    = i_tx_data;
            vld_d     = 1'b1;
            crc_en_d  = 1'b1;
            crc_rst_d = 1'b0;
            cnt_d     = cnt_acc;
            if (i_tx_last) begin
                rdy_d  = 1'b0;
                wait_d = '0;
`ifdef ETHMAC_TX_PAD_EN
                state_d = (cnt_acc < MIN_WORDS_W) ? ST_PAD : ST_WAIT_CRC;
`else
                state_d = ST_WAIT_CRC;
`endif
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wait_q    <= '0;
            ifg_q     <= '0;
            data_q    <= '0;
            vld_q     <= 1'b0;
            last_q    <= 1'b0;
            crc_en_q  <= 1'b0;
            crc_rst_q <= 1'b1;
            rdy_q     <= 1'b0;
            udr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            ifg_q     <= ifg_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            last_q    <= last_d;
            crc_en_q  <= crc_en_d;
            crc_rst_q <= crc_rst_d;
            rdy_q     <= rdy_d;
            udr_q     <= udr_d;
        end
    end

    assign o_tx_ready  = rdy_q;
    assign o_mac_data  = data_q;
    assign o_mac_valid = vld_q;
    assign o_mac_last  = last_q;
    assign o_crc_reset = crc_rst_q;
    assign o_crc_en    = crc_en_q;
    assign o_crc_data  = data_q;
    assign o_underrun  = udr_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ethmac_tx_fcs_ctrl.sv
`timescale 1ns/1ps
// Directed bench for ethmac_tx_fcs_ctrl: full-length, short, underrun, mid-frame reset and back-to-back frames.
// Outputs are recorded 1 ns after each rising edge and compared against hand-derived cycle positions.
// Inputs are driven between edges; every run is a fixed number of cycles so the bench always terminates.
module tb_ethmac_tx_fcs_ctrl;

    localparam int CRC_LAT = 2;
    localparam int IFG     = 6;
    localparam int NREC    = 128;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [15:0] i_tx_data = 16'h0;
    logic        i_tx_valid = 1'b0;
    logic        i_tx_last = 1'b0;
    logic        o_tx_ready;
    logic [15:0] o_mac_data;
    logic        o_mac_valid;
    logic        o_mac_last;
    logic        o_crc_reset;
    logic        o_crc_en;
    logic [15:0] o_crc_data;
    logic [31:0] i_crc = 32'h0;
    logic        o_underrun;
    logic        o_busy;

    always #5 i_clk = ~i_clk;

    ethmac_tx_fcs_ctrl dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_tx_data   (i_tx_data),
        .i_tx_valid  (i_tx_valid),
        .i_tx_last   (i_tx_last),
        .o_tx_ready  (o_tx_ready),
        .o_mac_data  (o_mac_data),
        .o_mac_valid (o_mac_valid),
        .o_mac_last  (o_mac_last),
        .o_crc_reset (o_crc_reset),
        .o_crc_en    (o_crc_en),
        .o_crc_data  (o_crc_data),
        .i_crc       (i_crc),
        .o_underrun  (o_underrun),
        .o_busy      (o_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Stimulus words and recorded per-cycle outputs.
    logic [15:0] st_dat  [0:63];
    logic        st_last [0:63];
    int          st_n;
    logic [15:0] exp_dat [0:63];

    logic        rec_vld  [0:NREC-1];
    logic        rec_last [0:NREC-1];
    logic        rec_en   [0:NREC-1];
    logic        rec_rst  [0:NREC-1];
    logic        rec_rdy  [0:NREC-1];
    logic        rec_udr  [0:NREC-1];
    logic        rec_busy [0:NREC-1];
    logic [15:0] rec_dat  [0:NREC-1];
    logic [15:0] rec_cdat [0:NREC-1];

    int a;
    int ndw;
    int nlast;

    task automatic run(input int ncyc);
        int   sent;
        logic acc;
        sent = 0;
        for (int t = 0; t < ncyc; t++) begin
            i_tx_valid = (sent < st_n);
            i_tx_data  = (sent < st_n) ? st_dat[sent] : 16'h0;
            i_tx_last  = (sent < st_n) ? st_last[sent] : 1'b0;
            acc        = o_tx_ready && i_tx_valid;
            @(posedge i_clk);
            #1;
            if (acc) sent++;
            rec_vld[t]  = o_mac_valid;
            rec_last[t] = o_mac_last;
            rec_en[t]   = o_crc_en;
            rec_rst[t]  = o_crc_reset;
            rec_rdy[t]  = o_tx_ready;
            rec_udr[t]  = o_underrun;
            rec_busy[t] = o_busy;
            rec_dat[t]  = o_mac_data;
            rec_cdat[t] = o_crc_data;
        end
        i_tx_valid = 1'b0;
        i_tx_last  = 1'b0;
        i_tx_data  = 16'h0;
    endtask

    task automatic find_first(input int ncyc, output int first);
        first = -1;
        for (int t = 0; t < ncyc; t++)
            if (rec_vld[t] && first < 0) first = t;
        check("first_word_seen", 40'(first >= 0), 40'd1);
        if (first < 0) first = 0;
    endtask

    // Data/pad words, CRC_LAT gap, FCS_HI, FCS_LO+last, IFG with CRC reset, ready back.
    task automatic check_frame(input string nm, input int s, input int n, input logic [31:0] crc);
        int p;
        for (int k = 0; k < n; k++)
            check($sformatf("%s_word%0d", nm, k),
                  40'({rec_vld[s+k], rec_en[s+k], rec_rst[s+k], rec_cdat[s+k], rec_dat[s+k]}),
                  40'({3'b110, exp_dat[k], exp_dat[k]}));
        p = s + n;
        for (int g = 0; g < CRC_LAT; g++)
            check($sformatf("%s_gap%0d", nm, g), 40'(rec_vld[p+g]), 40'd0);
        p = p + CRC_LAT;
        check({nm, "_fcs_hi"}, 40'({rec_vld[p], rec_en[p], rec_last[p], rec_dat[p]}),
              40'({3'b100, crc[31:16]}));
        check({nm, "_fcs_lo"}, 40'({rec_vld[p+1], rec_en[p+1], rec_last[p+1], rec_dat[p+1]}),
              40'({3'b101, crc[15:0]}));
        for (int i = 0; i < IFG; i++)
            check($sformatf("%s_ifg%0d", nm, i),
                  40'({rec_vld[p+2+i], rec_rst[p+2+i], rec_rdy[p+2+i]}), 40'(3'b010));
        check({nm, "_rdy_back"}, 40'(rec_rdy[p+2+IFG]), 40'd1);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_outputs",
              40'({o_mac_valid, o_mac_last, o_crc_en, o_crc_reset, o_tx_ready, o_underrun, o_busy, o_mac_data}),
              40'({7'b0001000, 16'h0000}));
        check("rst_crc_data", 40'(o_crc_data), 40'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        check("rdy_after_rst", 40'({o_tx_ready, o_crc_reset, o_busy}), 40'(3'b110));

        // 30-word frame: exactly the minimum, no padding.
        st_n = 30;
        for (int k = 0; k < 30; k++) begin
            st_dat[k]  = 16'(k + 1);
            st_last[k] = (k == 29);
            exp_dat[k] = 16'(k + 1);
        end
        i_crc = 32'h1234_5678;
        run(48);
        find_first(48, a);
        check("f30_latency", 40'(a), 40'd0);
        check_frame("f30", a, 30, 32'h1234_5678);
        check("f30_busy_mid", 40'(rec_busy[a+5]), 40'd1);
        check("f30_busy_idle", 40'(rec_busy[a+40]), 40'd0);

        // One-word frame.
        st_n       = 1;
        st_dat[0]  = 16'hABCD;
        st_last[0] = 1'b1;
        exp_dat[0] = 16'hABCD;
        for (int k = 1; k < 30; k++) exp_dat[k] = 16'h0000;
`ifdef ETHMAC_TX_PAD_EN
        ndw = 30;
`else
        ndw = 1;
`endif
        i_crc = 32'h9ABC_DEF0;
        run(48);
        find_first(48, a);
        check_frame("short", a, ndw, 32'h9ABC_DEF0);

        // Input gap after word 10.
        st_n = 10;
        for (int k = 0; k < 10; k++) begin
            st_dat[k]  = 16'h0100 + 16'(k);
            st_last[k] = 1'b0;
            exp_dat[k] = 16'h0100 + 16'(k);
        end
        i_crc = 32'hFFFF_0000;
        run(24);
        find_first(24, a);
        for (int k = 0; k < 10; k++)
            check($sformatf("udr_word%0d", k),
                  40'({rec_vld[a+k], rec_en[a+k], rec_dat[a+k]}), 40'({2'b11, exp_dat[k]}));
        check("udr_pulse", 40'({rec_vld[a+10], rec_udr[a+10]}), 40'(2'b01));
        check("udr_pulse_end", 40'(rec_udr[a+11]), 40'd0);
        for (int i = 0; i < IFG; i++)
            check($sformatf("udr_ifg%0d", i), 40'({rec_vld[a+10+i], rec_rst[a+10+i], rec_rdy[a+10+i]}),
                  40'(3'b010));
        check("udr_rdy_back", 40'(rec_rdy[a+16]), 40'd1);
        nlast = 0;
        for (int t = 0; t < 24; t++) if (rec_last[t]) nlast++;
        check("udr_no_last", 40'(nlast), 40'd0);

        // Reset in the middle of a 3-word frame (PAD state when padding is built in).
        st_n = 3;
        for (int k = 0; k < 3; k++) begin
            st_dat[k]  = 16'h0A0A + 16'(k);
            st_last[k] = (k == 2);
        end
        run(5);
`ifdef ETHMAC_TX_PAD_EN
        check("mid_pad_word", 40'({rec_vld[3], rec_en[3], rec_dat[3]}), 40'({2'b11, 16'h0000}));
`else
        check("mid_gap", 40'(rec_vld[3]), 40'd0);
`endif
        #2;
        i_rst_n = 1'b0;
        #1;
        check("mid_rst_outputs",
              40'({o_mac_valid, o_mac_last, o_crc_en, o_crc_reset, o_tx_ready, o_underrun, o_busy, o_mac_data}),
              40'({7'b0001000, 16'h0000}));
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        check("mid_rst_release", 40'({o_tx_ready, o_mac_valid, o_busy, o_underrun}), 40'(4'b1000));

        // Back-to-back frames with valid held high.
        st_n = 60;
        for (int k = 0; k < 60; k++) begin
            st_dat[k]  = (k < 30) ? 16'h2000 + 16'(k) : 16'h3000 + 16'(k - 30);
            st_last[k] = (k == 29) || (k == 59);
        end
        for (int k = 0; k < 30; k++) exp_dat[k] = 16'h2000 + 16'(k);
        i_crc = 32'h0BAD_F00D;
        run(90);
        find_first(90, a);
        check("b2b_latency", 40'(a), 40'd0);
        check_frame("b2b_a", a, 30, 32'h0BAD_F00D);
        for (int i = 34; i <= 40; i++)
            check($sformatf("b2b_crc_rst%0d", i), 40'(rec_rst[a+i]), 40'd1);
        check("b2b_quiet", 40'(rec_vld[a+40]), 40'd0);
        check("b2b_second_start", 40'({rec_vld[a+41], rec_dat[a+41]}), 40'({1'b1, 16'h3000}));
        for (int k = 0; k < 30; k++) exp_dat[k] = 16'h3000 + 16'(k);
        check_frame("b2b_b", a + 41, 30, 32'h0BAD_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
